// File: rtl/armleocpu_icache_lite.sv
// armleocpu_icache_lite: direct-mapped, one-word-per-line, read-only instruction cache.
// It sits between the fetch unit and the instruction memory.
// Misses are refilled through a single-word request/acknowledge port.
// Optional feature macro: ARMLEOCPU_ICACHE_PROTO_CHECK_EN. When it is defined,
// proto_err is a sticky flag for fetch-side protocol violations.
module armleocpu_icache_lite #(
  parameter int LANES_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic        c_done,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
  output logic        m_req,
  output logic [31:0] m_addr,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  input  logic        m_err,
  output logic        proto_err
);

  localparam int LINES = 1 << LANES_W;
  localparam int TAG_W = 30 - LANES_W;

  localparam logic [3:0] CMD_NONE         = 4'd0;
  localparam logic [3:0] CMD_EXECUTE      = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL    = 4'd4;
  localparam logic [3:0] RESP_SUCCESS     = 4'd0;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd1;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd3;
  localparam logic [3:0] RESP_UNKNOWNTYPE = 4'd4;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, FLUSH} state_t;

  state_t               state, state_next;
  logic [31:0]          addr_q;
  logic                 unknown_q;
  logic [LANES_W-1:0]   flush_cnt;
  logic [LINES-1:0]     valid;
  logic [31:0]          data_mem [LINES];
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [31:0]          data_rd;
  logic [TAG_W-1:0]     tag_rd;
  logic                 accept;
  logic                 refill_write;
  logic                 cmd_known;
  logic                 hit;
  logic [LANES_W-1:0]   idx_q;
  logic [LANES_W-1:0]   idx_in;
  logic [TAG_W-1:0]     tag_q;

  assign idx_q     = addr_q[LANES_W+1:2];
  assign tag_q     = addr_q[31:LANES_W+2];
  assign idx_in    = c_address[LANES_W+1:2];
  assign cmd_known = (c_cmd == CMD_EXECUTE) || (c_cmd == CMD_FLUSH_ALL);
  // The valid bits are read live, so flushes and refills that finished on the previous edge are seen.
  assign hit       = valid[idx_q] && (tag_rd == tag_q);

  // Compute the next state, the completion outputs, the refill request and command acceptance.
  always_comb begin
    state_next   = state;
    c_done       = 1'b0;
    c_response   = RESP_SUCCESS;
    c_load_data  = '0;
    m_req        = 1'b0;
    m_addr       = '0;
    refill_write = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: ;
      LOOKUP: begin
        if (unknown_q) begin
          c_done     = 1'b1;
          c_response = RESP_UNKNOWNTYPE;
        end else if (addr_q[1:0] != 2'b00) begin
          c_done     = 1'b1;
          c_response = RESP_MISSALIGNED;
        end else if (hit) begin
          c_done      = 1'b1;
          c_load_data = data_rd;
        end else begin
          m_req = 1'b1;
          if (!m_ack) state_next = REFILL;
        end
      end
      REFILL: m_req = 1'b1;
      FLUSH: if (flush_cnt == '1) c_done = 1'b1;
      default: state_next = IDLE;
    endcase
    // A zero-wait acknowledge can complete the refill in the lookup cycle itself.
    if (m_req) begin
      m_addr = {addr_q[31:2], 2'b00};
      if (m_ack) begin
        c_done = 1'b1;
        if (m_err) begin
          c_response = RESP_ACCESSFAULT;
        end else begin
          refill_write = 1'b1;
          c_load_data  = m_rdata;
        end
      end
    end
    if (c_done) state_next = IDLE;
    accept = (c_cmd != CMD_NONE) && ((state == IDLE) || c_done);
    if (accept) state_next = (c_cmd == CMD_FLUSH_ALL) ? FLUSH : LOOKUP;
  end

  // Hold the state, the registered request, the flush counter and the per-line valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      unknown_q <= 1'b0;
      flush_cnt <= '0;
      valid     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q    <= c_address;
        unknown_q <= !cmd_known;
      end
      if (state == FLUSH) begin
        valid[flush_cnt] <= 1'b0;
        flush_cnt        <= flush_cnt + 1'b1;
      end
      if (accept && (c_cmd == CMD_FLUSH_ALL)) flush_cnt <= '0;
      if (refill_write) valid[idx_q] <= 1'b1;
    end
  end

  // Store the tag and data arrays with a synchronous read. A refill of the same line is bypassed to the read.
  always_ff @(posedge clk) begin
    if (refill_write) begin
      data_mem[idx_q] <= m_rdata;
      tag_mem[idx_q]  <= tag_q;
    end
    if (accept) begin
      if (refill_write && (idx_in == idx_q)) begin
        data_rd <= m_rdata;
        tag_rd  <= tag_q;
      end else begin
        data_rd <= data_mem[idx_in];
        tag_rd  <= tag_mem[idx_in];
      end
    end
  end

`ifdef ARMLEOCPU_ICACHE_PROTO_CHECK_EN
  logic [3:0] cmd_q;
  logic       proto_err_q;

  // Flag a changed command or address while a request is pending, and flag an unsupported command at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= CMD_NONE;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) cmd_q <= c_cmd;
      if (accept && !cmd_known) proto_err_q <= 1'b1;
      if ((state != IDLE) && !c_done && ((c_cmd != cmd_q) || (c_address != addr_q)))
        proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_armleocpu_icache_lite.sv
// Testbench for armleocpu_icache_lite.
// A behavioural per-line model predicts each response and pushes it into a scoreboard.
// A monitor checks every c_done pulse against the scoreboard.
module tb_armleocpu_icache_lite;

  localparam int LANES_W = 6;
  localparam int LINES   = 1 << LANES_W;

  localparam logic [3:0] CMD_NONE         = 4'd0;
  localparam logic [3:0] CMD_EXECUTE      = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL    = 4'd4;
  localparam logic [3:0] RESP_SUCCESS     = 4'd0;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd1;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd3;
  localparam logic [3:0] RESP_UNKNOWNTYPE = 4'd4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic        c_done;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        proto_err;

  armleocpu_icache_lite #(.LANES_W(LANES_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_cmd(c_cmd), .c_address(c_address),
    .c_done(c_done), .c_response(c_response), .c_load_data(c_load_data),
    .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [3:0]  resp;
    logic [31:0] data;
    bit          miss;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks_total;
  int          checks_passed;
  int          cyc;
  bit          mreq_seen;

  bit          model_valid [LINES];
  logic [31:0] model_addr  [LINES];
  logic [31:0] model_data  [LINES];

  int          plan_lat;
  logic [31:0] plan_data;
  logic        plan_err;
  logic [31:0] exp_maddr;
  bit          maddr_checked;
  logic        exp_proto;

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc++;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Issue one command and predict its result. A miss is served by the planned memory response.
  // Returns at the negedge of the c_done cycle, so the caller can chain a back-to-back command.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] addr, input int lat,
                               input logic [31:0] data, input logic err, input bit glitch);
    exp_t e;
    int   line;
    bit   done;
    e.issue_cyc = cyc;
    e.miss      = 1'b0;
    e.data      = '0;
    e.lat       = 1;
    e.resp      = RESP_SUCCESS;
    line        = int'((addr >> 2) % LINES);
    if (cmd == CMD_FLUSH_ALL) begin
      for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
      e.lat = LINES;
    end else if (cmd != CMD_EXECUTE) begin
      e.resp = RESP_UNKNOWNTYPE;
    end else if ((addr % 4) != 0) begin
      e.resp = RESP_MISSALIGNED;
    end else if (model_valid[line] && model_addr[line] == addr) begin
      e.data = model_data[line];
    end else begin
      e.miss = 1'b1;
      e.lat  = 1 + lat;
      if (err) begin
        e.resp = RESP_ACCESSFAULT;
      end else begin
        e.data            = data;
        model_valid[line] = 1'b1;
        model_addr[line]  = addr;
        model_data[line]  = data;
      end
    end
    sb.push_back(e);
    plan_lat      = lat;
    plan_data     = data;
    plan_err      = err;
    exp_maddr     = addr & 32'hFFFF_FFFC;
    maddr_checked = 1'b0;
    c_cmd         = cmd;
    c_address     = addr;
    done          = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #2;
      if (c_done) done = 1'b1;
      else if (glitch && i == 0) begin
        @(negedge clk);
        c_address = addr + 32'd4;
      end
    end
    if (!done) begin
      checks_total++;
      $display("[TB] FAIL timeout: no c_done within 200 cycles for cmd %0d addr 0x%0h", cmd, addr);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
    end
    @(negedge clk);
  endtask

  // Memory model: acknowledges each refill after the planned number of wait cycles and checks the refill address.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    m_ack    = 1'b0;
    m_rdata  = '0;
    m_err    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_ack    = 1'b0;
        wait_cnt = 0;
        continue;
      end
      if (m_ack) begin
        m_ack    = 1'b0;
        m_rdata  = '0;
        m_err    = 1'b0;
        wait_cnt = 0;
      end
      if (m_req) begin
        if (!maddr_checked) begin
          checkOutput("m_addr", m_addr, exp_maddr);
          maddr_checked = 1'b1;
        end
        if (wait_cnt >= plan_lat) begin
          m_ack   = 1'b1;
          m_rdata = plan_data;
          m_err   = plan_err;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: on every c_done pulse, pop the prediction and compare response, data, latency and refill activity.
  initial begin
    exp_t e;
    mreq_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mreq_seen = 1'b0;
        continue;
      end
      if (m_req) mreq_seen = 1'b1;
      if (c_done) begin
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("c_response", 32'(c_response), 32'(e.resp));
          if (e.resp == RESP_SUCCESS) checkOutput("c_load_data", c_load_data, e.data);
          checkOutput("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
          checkOutput("m_req_seen", 32'(mreq_seen), 32'(e.miss));
        end
        mreq_seen = 1'b0;
      end
    end
  end

  // Directed scenarios first, then a randomized mix of hits, misses, faults, flushes and bad commands.
  initial begin
    logic [3:0]  cmd;
    logic [31:0] addr;
    checks_total  = 0;
    checks_passed = 0;
    cyc           = 0;
    plan_lat      = 0;
    plan_data     = '0;
    plan_err      = 1'b0;
    exp_maddr     = '0;
    maddr_checked = 1'b1;
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
`ifdef ARMLEOCPU_ICACHE_PROTO_CHECK_EN
    exp_proto = 1'b1;
`else
    exp_proto = 1'b0;
`endif
    rst_n     = 1'b0;
    c_cmd     = CMD_NONE;
    c_address = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_c_done", 32'(c_done), 32'd0);
    checkOutput("rst_c_response", 32'(c_response), 32'(RESP_SUCCESS));
    checkOutput("rst_c_load_data", c_load_data, 32'd0);
    checkOutput("rst_m_req", 32'(m_req), 32'd0);
    checkOutput("rst_m_addr", m_addr, 32'd0);
    checkOutput("rst_proto_err", 32'(proto_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(CMD_EXECUTE, 32'h1000, 2, 32'h0000_0013, 1'b0, 1'b0);
    applyStimulus(CMD_EXECUTE, 32'h1000, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(CMD_EXECUTE, 32'h1002, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(CMD_EXECUTE, 32'h2000, 1, 32'h1234_5678, 1'b1, 1'b0);
    applyStimulus(CMD_EXECUTE, 32'h2000, 0, 32'h0000_0067, 1'b0, 1'b0);
    applyStimulus(CMD_FLUSH_ALL, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    applyStimulus(CMD_EXECUTE, 32'h1000, 1, 32'h0000_0013, 1'b0, 1'b0);
    c_cmd = CMD_NONE;
    repeat (2) @(negedge clk);
    checkOutput("idle_c_response", 32'(c_response), 32'(RESP_SUCCESS));

    applyStimulus(CMD_EXECUTE, 32'h3000, 3, 32'hCAFE_0001, 1'b0, 1'b1);
    c_cmd = CMD_NONE;
    @(negedge clk);
    checkOutput("proto_err_after_change", 32'(proto_err), 32'(exp_proto));

    for (int n = 0; n < 300; n++) begin
      int r;
      r    = $urandom_range(0, 99);
      addr = ($urandom_range(4, 7) << (LANES_W + 2)) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 9) == 0) addr = addr | $urandom_range(1, 3);
      if (r < 3) cmd = CMD_FLUSH_ALL;
      else if (r < 8) cmd = 4'($urandom_range(2, 3));
      else cmd = CMD_EXECUTE;
      applyStimulus(cmd, addr, $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        c_cmd = CMD_NONE;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    c_cmd = CMD_NONE;
    repeat (4) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("proto_err_final", 32'(proto_err), 32'(exp_proto));
    $display("[TB] random phase complete");
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
